// File: rtl/hw_sw_byte_link.sv
// Fabric-side endpoint of the byte-wide PIO handshake with the Nios II: assembles
// MSB-first messages for the core and streams the core's result back byte by byte.
module hw_sw_byte_link #(
  parameter int NBYTES      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [7:0]          to_hw_port_export,
  input  logic [1:0]          to_hw_sig_export,
  output logic [7:0]          to_sw_port_export,
  output logic [1:0]          to_sw_sig_export,
  output logic [8*NBYTES-1:0] rx_data,
  output logic                rx_valid,
  input  logic [8*NBYTES-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                busy
);

  localparam int            CW   = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WR    = 2'b01;
  localparam logic [1:0] CMD_RD    = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  // state      | meaning
  // S_IDLE     | waiting for a write byte (cnt = bytes already received)
  // S_WR_ACK   | byte latched, acking until software returns to idle
  // S_WAIT_RES | message delivered, waiting for the core's result
  // S_RES_RDY  | result buffered, waiting for a read request
  // S_RD_ACK   | byte on to_sw_port, waiting for software to return to idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACK,
    S_WAIT_RES,
    S_RES_RDY,
    S_RD_ACK
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][7:0] port_sync_q, port_sync_d;
  logic [SYNC_STAGES-1:0][1:0] sig_sync_q, sig_sync_d;
  logic [7:0]                  port_s;
  logic [1:0]                  sig_s;

  logic [CW-1:0]               cnt_q, cnt_d;
  logic [CW-1:0]               byte_idx;
  logic [NBYTES-1:0][7:0]      asm_q, asm_d;
  logic [NBYTES-1:0][7:0]      rx_data_q, rx_data_d;
  logic [NBYTES-1:0][7:0]      tx_buf_q, tx_buf_d;
  logic                        rx_valid_q, rx_valid_d;
  logic                        tx_ready_q, tx_ready_d;
  logic [7:0]                  port_out_q, port_out_d;
  logic [1:0]                  sig_out_q, sig_out_d;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_comb begin
        port_sync_d = to_hw_port_export;
        sig_sync_d  = to_hw_sig_export;
      end
    end else begin : g_sync_chain
      always_comb begin
        port_sync_d = {port_sync_q[SYNC_STAGES-2:0], to_hw_port_export};
        sig_sync_d  = {sig_sync_q[SYNC_STAGES-2:0], to_hw_sig_export};
      end
    end
  endgenerate

  assign port_s = port_sync_q[SYNC_STAGES-1];
  assign sig_s  = sig_sync_q[SYNC_STAGES-1];

  // Byte k lives in packed element NBYTES-1-k, which places it MSB first.
  assign byte_idx = LAST - cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_buf_d   = tx_buf_q;
    port_out_d = port_out_q;

    if (sig_s == CMD_ABORT) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      port_out_d = '0;
      tx_buf_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sig_s == CMD_WR) begin
            asm_d[byte_idx] = port_s;
            state_d         = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (sig_s == CMD_IDLE) begin
            if (cnt_q == LAST) begin
              // Assembly buffer is separate so an abort never disturbs rx_data.
              rx_valid_d = 1'b1;
              rx_data_d  = asm_q;
              cnt_d      = '0;
              state_d    = S_WAIT_RES;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_WAIT_RES: begin
          if (tx_ready_q && tx_valid) begin
            tx_buf_d = tx_data;
            state_d  = S_RES_RDY;
          end
        end
        S_RES_RDY: begin
          if (sig_s == CMD_RD) begin
            port_out_d = tx_buf_q[byte_idx];
            state_d    = S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (sig_s == CMD_IDLE) begin
            if (cnt_q == LAST) begin
              cnt_d      = '0;
              port_out_d = '0;
              state_d    = S_IDLE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = S_RES_RDY;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_WR_ACK:  sig_out_d = 2'b01;
      S_RES_RDY: sig_out_d = 2'b11;
      S_RD_ACK:  sig_out_d = 2'b10;
      default:   sig_out_d = 2'b00;
    endcase

    // Ready only from the second S_WAIT_RES cycle, so it never overlaps rx_valid.
    tx_ready_d = (state_q == S_WAIT_RES) && (state_d == S_WAIT_RES);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      port_sync_q <= '0;
      sig_sync_q  <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b0;
      port_out_q  <= '0;
      sig_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      port_sync_q <= port_sync_d;
      sig_sync_q  <= sig_sync_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      port_out_q  <= port_out_d;
      sig_out_q   <= sig_out_d;
    end
  end

  assign to_sw_port_export = port_out_q;
  assign to_sw_sig_export  = sig_out_q;
  assign rx_data           = rx_data_q;
  assign rx_valid          = rx_valid_q;
  assign tx_ready          = tx_ready_q;
  assign busy              = !((state_q == S_IDLE) && (cnt_q == '0));

endmodule

// File: tb/tb_hw_sw_byte_link.sv
// Randomised bench for hw_sw_byte_link: software-side handshakes driven against a
// message/result model (byte lists packed MSB first), plus a latency sweep on small instances.
`timescale 1ns/1ps
module tb_hw_sw_byte_link;

  logic         clk = 1'b0;
  logic         rst_n;
  always #5 clk = ~clk;

  // Main instance: NBYTES=16, SYNC_STAGES=2
  logic [7:0]   port;
  logic [1:0]   sig;
  logic [127:0] tx_data;
  logic         tx_valid;
  logic [7:0]   sw_port;
  logic [1:0]   sw_sig;
  logic [127:0] rx_data;
  logic         rx_valid, tx_ready, busy;

  // Small instances: NBYTES=2 with SYNC_STAGES 1 and 3, sharing inputs
  logic [7:0]   s_port;
  logic [1:0]   s_sig;
  logic [15:0]  s_txd;
  logic         s_txv;
  logic [7:0]   a_port, b_port;
  logic [1:0]   a_sig, b_sig;
  logic [15:0]  a_rx, b_rx;
  logic         a_rxv, b_rxv, a_rdy, b_rdy, a_busy, b_busy;

  hw_sw_byte_link #(.NBYTES(16), .SYNC_STAGES(2)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .to_hw_port_export(port), .to_hw_sig_export(sig),
    .to_sw_port_export(sw_port), .to_sw_sig_export(sw_sig),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy));

  hw_sw_byte_link #(.NBYTES(2), .SYNC_STAGES(1)) dut_s1 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .to_hw_port_export(s_port), .to_hw_sig_export(s_sig),
    .to_sw_port_export(a_port), .to_sw_sig_export(a_sig),
    .rx_data(a_rx), .rx_valid(a_rxv),
    .tx_data(s_txd), .tx_valid(s_txv), .tx_ready(a_rdy), .busy(a_busy));

  hw_sw_byte_link #(.NBYTES(2), .SYNC_STAGES(3)) dut_s3 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .to_hw_port_export(s_port), .to_hw_sig_export(s_sig),
    .to_sw_port_export(b_port), .to_sw_sig_export(b_sig),
    .rx_data(b_rx), .rx_valid(b_rxv),
    .tx_data(s_txd), .tx_valid(s_txv), .tx_ready(b_rdy), .busy(b_busy));

  int n_checks = 0;
  int n_pass   = 0;

  int           rx_cnt = 0, a_rx_cnt = 0, b_rx_cnt = 0, collide = 0;
  logic [127:0] rx_last = '0;
  logic [15:0]  a_rx_last = '0, b_rx_last = '0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_last = rx_data;
      if (tx_ready) collide++;
    end
    if (a_rxv) begin a_rx_cnt++; a_rx_last = a_rx; end
    if (b_rxv) begin b_rx_cnt++; b_rx_last = b_rx; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Software-side driver: one four-phase write. lat = edges until ack seen.
  task automatic wr_byte(input logic [7:0] b, output int lat, output bit ok);
    port = b;
    @(negedge clk);
    sig = 2'b01;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (sw_sig == 2'b01) begin ok = 1'b1; break; end
    end
    sig = 2'b00;
    repeat (4) @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic rd_byte(output logic [7:0] got, output logic [7:0] got2, output bit ok);
    sig = 2'b10;
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sw_sig == 2'b10) begin ok = 1'b1; break; end
    end
    got = sw_port;
    @(negedge clk);
    got2 = sw_port;
    sig = 2'b00;
    repeat (4) @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic do_write(input logic [127:0] msg);
    logic [127:0] expect_w;
    logic [7:0]   b;
    int           lat, base;
    bit           ok;
    base     = rx_cnt;
    expect_w = '0;
    for (int k = 0; k < 16; k++) begin
      b        = msg[8*(15-k) +: 8];
      expect_w = {expect_w[119:0], b};
      wr_byte(b, lat, ok);
      n_checks++;
      if (!ok || lat != 3) $display("FAIL write_ack byte %0d: latency %0d (ok=%0d) expected 3", k, lat, ok);
      else n_pass++;
    end
    n_checks++;
    if (rx_cnt != base + 1) $display("FAIL rx_valid_count: got %0d pulses expected 1", rx_cnt - base);
    else n_pass++;
    n_checks++;
    if (rx_last !== expect_w) $display("FAIL rx_data: got %h expected %h", rx_last, expect_w);
    else n_pass++;
    n_checks++;
    if (tx_ready !== 1'b1 || collide != 0) $display("FAIL tx_ready_after_write: got %b collide %0d expected 1/0", tx_ready, collide);
    else n_pass++;
  endtask

  task automatic do_read(input logic [127:0] d);
    logic [7:0] got, got2, exp_b;
    bit         ok;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 128'($urandom);
    n_checks++;
    if (sw_sig !== 2'b11 || tx_ready !== 1'b0) $display("FAIL result_ready: sw_sig %b tx_ready %b expected 11/0", sw_sig, tx_ready);
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      exp_b = d[8*(15-k) +: 8];
      rd_byte(got, got2, ok);
      n_checks++;
      if (!ok || got !== exp_b || got2 !== exp_b)
        $display("FAIL read_byte %0d: got %h/%h (ok=%0d) expected %h", k, got, got2, ok, exp_b);
      else n_pass++;
    end
    n_checks++;
    if (sw_sig !== 2'b00 || sw_port !== 8'h00 || busy !== 1'b0)
      $display("FAIL read_done: sw_sig %b sw_port %h busy %b expected 00/00/0", sw_sig, sw_port, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      port = 8'($urandom); sig = 2'($urandom); tx_data = {4{32'($urandom)}}; tx_valid = 1'($urandom);
      s_port = 8'($urandom); s_sig = 2'($urandom); s_txd = 16'($urandom); s_txv = 1'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if ({sw_port, sw_sig, rx_valid, tx_ready, busy} !== 13'd0 || rx_data !== 128'd0)
      $display("FAIL reset_outputs: port %h sig %b rxv %b rdy %b busy %b rx %h expected all 0",
               sw_port, sw_sig, rx_valid, tx_ready, busy, rx_data);
    else n_pass++;
    n_checks++;
    if ({a_port, a_sig, a_rxv, a_rdy, a_busy, b_port, b_sig, b_rxv, b_rdy, b_busy} !== 26'd0 || a_rx !== 16'd0 || b_rx !== 16'd0)
      $display("FAIL reset_small: a_sig %b b_sig %b a_rx %h b_rx %h expected 0", a_sig, b_sig, a_rx, b_rx);
    else n_pass++;
    sig = 2'b00; s_sig = 2'b00; tx_valid = 1'b0; s_txv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (sw_sig !== 2'b00 || busy !== 1'b0 || tx_ready !== 1'b0)
      $display("FAIL reset_release: sw_sig %b busy %b tx_ready %b expected 00/0/0", sw_sig, busy, tx_ready);
    else n_pass++;
  endtask

  task automatic test_full_write();
    logic [127:0] msg;
    for (int k = 0; k < 16; k++) msg[8*(15-k) +: 8] = 8'(k);
    do_write(msg);
  endtask

  task automatic test_result();
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*(15-k) +: 8] = {4'(15 - k), 4'(k)};
    do_read(d);
  endtask

  task automatic test_abort();
    logic [127:0] msg, kept;
    int           lat, base;
    bit           ok;
    base = rx_cnt;
    kept = rx_last;
    for (int k = 0; k < 5; k++) wr_byte(8'($urandom), lat, ok);
    sig = 2'b11;
    repeat (8) @(negedge clk);
    n_checks++;
    if (sw_sig !== 2'b00 || busy !== 1'b0 || rx_cnt != base || rx_data !== kept)
      $display("FAIL abort_write: sw_sig %b busy %b pulses %0d rx %h expected 00/0/0/%h",
               sw_sig, busy, rx_cnt - base, rx_data, kept);
    else n_pass++;
    sig = 2'b00;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) msg[8*(15-k) +: 8] = 8'(8'hAA + k);
    do_write(msg);
    sig = 2'b11;
    repeat (6) @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b0 || rx_data !== msg)
      $display("FAIL abort_wait_res: tx_ready %b busy %b rx %h expected 0/0/%h", tx_ready, busy, rx_data, msg);
    else n_pass++;
    sig = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_protocol_errors();
    logic [127:0] msg, d;
    int           base;
    base     = rx_cnt;
    sig      = 2'b10;
    tx_valid = 1'b1;
    tx_data  = {4{32'($urandom)}};
    repeat (8) @(negedge clk);
    n_checks++;
    if (sw_sig !== 2'b00 || sw_port !== 8'h00 || tx_ready !== 1'b0 || busy !== 1'b0 || rx_cnt != base)
      $display("FAIL idle_errors: sw_sig %b sw_port %h tx_ready %b busy %b expected 00/00/0/0",
               sw_sig, sw_port, tx_ready, busy);
    else n_pass++;
    sig      = 2'b00;
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    msg = {4{32'($urandom)}};
    do_write(msg);
    repeat (3) @(negedge clk);
    n_checks++;
    if (sw_sig !== 2'b00 || tx_ready !== 1'b1)
      $display("FAIL no_stale_result: sw_sig %b tx_ready %b expected 00/1", sw_sig, tx_ready);
    else n_pass++;
    d = {4{32'($urandom)}};
    do_read(d);
  endtask

  task automatic test_random_transactions();
    logic [127:0] msg, d;
    logic [7:0]   got, got2;
    bit           ok;
    for (int r = 0; r < 3; r++) begin
      msg = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      d   = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      do_write(msg);
      do_read(d);
    end
    msg = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    do_write(msg);
    tx_data = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) rd_byte(got, got2, ok);
    sig = 2'b11;
    repeat (6) @(negedge clk);
    n_checks++;
    if (sw_sig !== 2'b00 || sw_port !== 8'h00 || busy !== 1'b0)
      $display("FAIL abort_read: sw_sig %b sw_port %h busy %b expected 00/00/0", sw_sig, sw_port, busy);
    else n_pass++;
    sig = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency_sweep();
    logic [7:0]  b [2];
    logic [15:0] d;
    int          la, lb;
    b[0] = 8'($urandom);
    b[1] = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      s_port = b[k];
      @(negedge clk);
      s_port = 8'($urandom);
      s_port = b[k];
      s_sig  = 2'b01;
      la = 0;
      lb = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (la == 0 && a_sig == 2'b01) la = i;
        if (lb == 0 && b_sig == 2'b01) lb = i;
      end
      n_checks++;
      if (la != 2 || lb != 4) $display("FAIL sync_latency byte %0d: got %0d/%0d expected 2/4", k, la, lb);
      else n_pass++;
      s_sig = 2'b00;
      repeat (8) @(negedge clk);
    end
    n_checks++;
    if (a_rx_cnt != 1 || b_rx_cnt != 1 || a_rx_last !== {b[0], b[1]} || b_rx_last !== {b[0], b[1]})
      $display("FAIL small_rx: pulses %0d/%0d data %h/%h expected 1/1 %h",
               a_rx_cnt, b_rx_cnt, a_rx_last, b_rx_last, {b[0], b[1]});
    else n_pass++;
    d     = 16'($urandom);
    s_txd = d;
    s_txv = 1'b1;
    @(negedge clk);
    s_txv = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s_sig = 2'b10;
      repeat (6) @(negedge clk);
      n_checks++;
      if (a_sig !== 2'b10 || b_sig !== 2'b10 || a_port !== d[8*(1-k) +: 8] || b_port !== d[8*(1-k) +: 8])
        $display("FAIL small_read byte %0d: sig %b/%b port %h/%h expected 10 %h",
                 k, a_sig, b_sig, a_port, b_port, d[8*(1-k) +: 8]);
      else n_pass++;
      s_sig = 2'b00;
      repeat (6) @(negedge clk);
    end
    n_checks++;
    if (a_sig !== 2'b00 || b_sig !== 2'b00 || a_port !== 8'h00 || b_port !== 8'h00 || a_busy !== 1'b0 || b_busy !== 1'b0)
      $display("FAIL small_done: sig %b/%b port %h/%h busy %b/%b expected idle",
               a_sig, b_sig, a_port, b_port, a_busy, b_busy);
    else n_pass++;
  endtask

  initial begin
    port = '0; sig = '0; tx_data = '0; tx_valid = 1'b0;
    s_port = '0; s_sig = '0; s_txd = '0; s_txv = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_full_write();
    test_result();
    test_abort();
    test_protocol_errors();
    test_random_transactions();
    test_latency_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hw_sw_byte_link.md
Name: hw_sw_byte_link

Overview:
- Hardware-side endpoint of the byte-wide PIO handshake between the Nios II software and the fabric.
- Software sends a message one byte at a time on to_hw_port/to_hw_sig; the block assembles it and hands a full word to the datapath core.
- The block accepts the core's result word, then returns it to software byte-by-byte on to_sw_port/to_sw_sig.
- Sits in the top level between the lab9_soc PIO exports and the processing core.

Parameters:
- NBYTES, 16, bytes per message/result word (word width = 8*NBYTES); legal 2..32
- SYNC_STAGES, 2, flop stages on to_hw_port/to_hw_sig before decode; legal 1..3

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- to_hw_port_export  in  8  byte from software
- to_hw_sig_export  in  2  software command: 00 idle, 01 write byte valid, 10 read request, 11 abort
- to_sw_port_export  out  8  byte to software
- to_sw_sig_export  out  2  hardware status: 00 idle, 01 write ack, 10 read byte valid, 11 result ready
- rx_data  out  8*NBYTES  assembled message; held until next rx_valid
- rx_valid  out  1  one-cycle pulse when rx_data is complete
- tx_data  in  8*NBYTES  result from core
- tx_valid  in  1  result qualifier; accepted only while tx_ready=1
- tx_ready  out  1  block can accept a result
- busy  out  1  high in any state other than S_IDLE with byte count 0

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low. All outputs, sync flops, the count, rx_data and the tx buffer clear to 0. State resets to S_IDLE.
- Input synchronisation: to_hw_port and to_hw_sig pass through SYNC_STAGES flops. All decode uses the synchronised values (sig_s, port_s).
- Response latency: a change on to_hw_sig produces the registered status change SYNC_STAGES+1 cycles later.
- Byte order: byte k (k=0 first transferred) maps to bits [8*(NBYTES-k)-1 -: 8], i.e. MSB first, in both directions.
- Byte count: cnt is a $clog2(NBYTES)-bit counter. It is shared by the write and read phases and is cleared on phase completion and on abort.
- S_IDLE: to_sw_sig=00.
  - sig_s=01: latch port_s into byte cnt of rx_data, go to S_WR_ACK.
  - sig_s=10: protocol error; ignore and stay.
- S_WR_ACK: to_sw_sig=01. Wait for sig_s=00.
  - If cnt=NBYTES-1: pulse rx_valid for one cycle, clear cnt, go to S_WAIT_RES.
  - Otherwise: cnt++, go to S_IDLE.
- S_WAIT_RES: to_sw_sig=00, tx_ready=1.
  - tx_valid=1: load tx buffer, drop tx_ready the next cycle, go to S_RES_RDY.
  - Software commands 01 and 10 are ignored.
- S_RES_RDY: to_sw_sig=11.
  - sig_s=10: drive to_sw_port with byte cnt of the tx buffer, go to S_RD_ACK.
- S_RD_ACK: to_sw_sig=10. to_sw_port is held stable. Wait for sig_s=00.
  - If cnt=NBYTES-1: clear cnt, to_sw_port=00, go to S_IDLE.
  - Otherwise: cnt++, go to S_RES_RDY.
- Abort: sig_s=11 in any state takes priority.
  - Next state S_IDLE, cnt=0, to_sw_port=00, to_sw_sig=00.
  - No rx_valid pulse. The tx buffer is discarded.
  - The block stays in S_IDLE while sig_s=11.
- rx_data is not cleared by abort. It keeps the last completed message.
- tx_valid outside S_WAIT_RES is ignored; no buffering.
- The rx_valid pulse and tx_valid in the same cycle cannot collide, because tx_ready=0 until the cycle after rx_valid.
- Reset asserted mid-transfer: immediate return to the reset state; the partial message is lost.

Test Plan:
- Reset: hold reset_reset_n=0 with random inputs -> all outputs 0, busy=0; release -> S_IDLE, to_sw_sig=00.
- Full write, NBYTES=16: bytes 0x00..0x0F, each with four-phase 01/00 handshake -> to_sw_sig 01 within SYNC_STAGES+1 cycles of each 01; single rx_valid pulse with rx_data=0x000102...0E0F; tx_ready=1.
- Result return: tx_data=0xF0E1...0F with tx_valid for 1 cycle -> to_sw_sig=11. Sixteen 10/00 read handshakes return 0xF0,0xE1,...,0x0F, with to_sw_sig=10 during each. Then S_IDLE and to_sw_port=00.
- Abort mid-write: after 5 bytes send sig=11 then 00 -> no rx_valid, cnt=0. A new 16-byte write 0xAA.. produces rx_valid with all 16 bytes correct.
- Protocol errors: sig=10 in S_IDLE and tx_valid in S_IDLE -> no state change, to_sw_sig=00, no read data.
- Latency/sync sweep: SYNC_STAGES=1 and 3, NBYTES=2 -> ack latency exactly 2 and 4 cycles; rx_data correct when to_hw_port is changed one cycle before sig=01.
